// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the 32x32 register file's single write port among
// NREQ writeback sources. It uses round-robin arbitration with a valid/ready
// handshake. After each reset it optionally writes zero to x1..x31 before
// arbitration starts.
module regfile_wb_arbiter #(
    parameter int NREQ      = 3,
    parameter int INIT_ZERO = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we,
    output logic [4:0]           waddr,
    output logic [31:0]          wdata,
    output logic                 init_done
);

    localparam int          PW     = $clog2(NREQ);
    localparam logic [31:0] NREQ_U = 32'(NREQ);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Reset lands in INIT only when the clear sequence is enabled.
    localparam state_t RESET_STATE     = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    localparam logic   RESET_INIT_DONE = (INIT_ZERO == 0);

    state_t          state_reg, state_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic            we_reg, we_next;
    logic [4:0]      waddr_reg, waddr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic            init_done_reg, init_done_next;

    logic [4:0]      addr_arr [NREQ];
    logic [31:0]     data_arr [NREQ];
    logic [PW-1:0]   cand_idx [NREQ];
    logic [31:0]     cand_sum [NREQ];

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic            xfer;

    // Unpack the flat requester buses. Also list the candidates in scan order:
    // candidate gi is requester (rr_ptr + 1 + gi) mod NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[5*gi +: 5];
            assign data_arr[gi] = req_data[32*gi +: 32];
            assign cand_sum[gi] = {{(32-PW){1'b0}}, rr_ptr_reg} + 32'(gi) + 32'd1;
            assign cand_idx[gi] = PW'(cand_sum[gi] % NREQ_U);
        end
    endgenerate

    // Rotating priority. The loop runs from the last candidate down to the
    // first, so the earliest valid candidate in scan order wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[cand_idx[k]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    // A grant is only issued in RUN and never while reset is asserted.
    // A grant always goes to a valid requester, so a grant is also a transfer.
    assign xfer = (state_reg == ST_RUN) && !rst_in && grant_found;

    // One-hot ready vector, decoded from the winning index.
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (grant_idx == PW'(gi));
        end
    endgenerate

    // Next-state and next-output logic for the INIT clear sequence and RUN arbitration.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rr_ptr_next    = rr_ptr_reg;
        we_next        = 1'b0;
        waddr_next     = waddr_reg;
        wdata_next     = wdata_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            ST_INIT: begin
                we_next    = 1'b1;
                waddr_next = cnt_reg;
                wdata_next = 32'd0;
                cnt_next   = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    state_next     = ST_RUN;
                    init_done_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    rr_ptr_next = grant_idx;
                    waddr_next  = addr_arr[grant_idx];
                    wdata_next  = data_arr[grant_idx];
                    // A write to x0 completes the handshake but is dropped.
                    we_next     = (addr_arr[grant_idx] != 5'd0);
                end
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    // State and output registers. Reset aborts any clear or arbitration in progress.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= RESET_STATE;
            cnt_reg       <= 5'd1;
            rr_ptr_reg    <= PW'(NREQ - 1);
            we_reg        <= 1'b0;
            waddr_reg     <= 5'd0;
            wdata_reg     <= 32'd0;
            init_done_reg <= RESET_INIT_DONE;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rr_ptr_reg    <= rr_ptr_next;
            we_reg        <= we_next;
            waddr_reg     <= waddr_next;
            wdata_reg     <= wdata_next;
            init_done_reg <= init_done_next;
        end
    end

    assign we        = we_reg;
    assign waddr     = waddr_reg;
    assign wdata     = wdata_reg;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, INIT_ZERO=1).
// It covers the clear sequence, round-robin order, x0 drop and reset in INIT and RUN.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic [NREQ-1:0]    req_valid;
    logic [5*NREQ-1:0]  req_addr;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               we;
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic               init_done;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .INIT_ZERO(1)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .init_done (init_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then wait for the registers to settle.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]   = a;
        req_data[32*i +: 32] = d;
    endtask

    initial begin
        rst_in    = 1'b1;
        req_valid = 3'b111;
        req_addr  = '0;
        req_data  = '0;
        set_req(0, 5'd5, 32'hA);
        set_req(1, 5'd6, 32'hB);
        set_req(2, 5'd7, 32'hC);

        // Reset state.
        tick();
        tick();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        $display("reset: we=%0b waddr=%0d init_done=%0b", we, waddr, init_done);

        // Clear sequence with all requesters valid. The first grant (req 0)
        // appears in the cycle presenting waddr=31.
        rst_in = 1'b0;
        #1;
        chk("init_ready_pre", {29'd0, req_ready}, 32'd0);
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("init_we", {31'd0, we}, 32'd1);
            chk("init_waddr", {27'd0, waddr}, 32'(k));
            chk("init_wdata", wdata, 32'd0);
            chk("init_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
            chk("init_ready", {29'd0, req_ready}, (k == 31) ? 32'd1 : 32'd0);
            $display("init: cycle=%0d we=%0b waddr=%0d ready=%b", k, we, waddr, req_ready);
        end

        // Round robin 0,1,2. Each requester drops valid once it has been served.
        tick();
        req_valid = 3'b110;
        chk("rr_w0_we", {31'd0, we}, 32'd1);
        chk("rr_w0_addr", {27'd0, waddr}, 32'd5);
        chk("rr_w0_data", wdata, 32'hA);
        #1;
        chk("rr_g1", {29'd0, req_ready}, 32'b010);
        $display("rr: write addr=%0d data=%h next ready=%b", waddr, wdata, req_ready);
        tick();
        req_valid = 3'b100;
        chk("rr_w1_addr", {27'd0, waddr}, 32'd6);
        chk("rr_w1_data", wdata, 32'hB);
        #1;
        chk("rr_g2", {29'd0, req_ready}, 32'b100);
        $display("rr: write addr=%0d data=%h next ready=%b", waddr, wdata, req_ready);
        tick();
        req_valid = 3'b000;
        chk("rr_w2_we", {31'd0, we}, 32'd1);
        chk("rr_w2_addr", {27'd0, waddr}, 32'd7);
        chk("rr_w2_data", wdata, 32'hC);
        #1;
        chk("rr_idle_ready", {29'd0, req_ready}, 32'd0);
        $display("rr: write addr=%0d data=%h", waddr, wdata);
        tick();
        chk("idle_we", {31'd0, we}, 32'd0);
        chk("idle_waddr_hold", {27'd0, waddr}, 32'd7);
        chk("idle_wdata_hold", wdata, 32'hC);
        $display("idle: we=%0b waddr=%0d wdata=%h", we, waddr, wdata);

        // Make requester 0 the last one granted, then keep 0 and 2 valid.
        set_req(0, 5'd3, 32'h33);
        req_valid = 3'b001;
        #1;
        chk("pre_g0", {29'd0, req_ready}, 32'b001);
        tick();
        chk("pre_w0_addr", {27'd0, waddr}, 32'd3);
        $display("prep: write addr=%0d data=%h", waddr, wdata);
        set_req(0, 5'd8, 32'h80);
        set_req(2, 5'd10, 32'h100);
        req_valid = 3'b101;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("alt_ready", {29'd0, req_ready}, (k % 2 == 0) ? 32'b100 : 32'b001);
            tick();
            chk("alt_we", {31'd0, we}, 32'd1);
            chk("alt_waddr", {27'd0, waddr}, (k % 2 == 0) ? 32'd10 : 32'd8);
            $display("alt: step=%0d write addr=%0d data=%h", k, waddr, wdata);
        end
        req_valid = 3'b000;

        // A write to x0 handshakes once and is then dropped.
        set_req(1, 5'd0, 32'hDEADBEEF);
        req_valid = 3'b010;
        #1;
        chk("x0_ready", {29'd0, req_ready}, 32'b010);
        tick();
        req_valid = 3'b000;
        chk("x0_we", {31'd0, we}, 32'd0);
        #1;
        chk("x0_ready_after", {29'd0, req_ready}, 32'd0);
        $display("x0: we=%0b ready=%b", we, req_ready);

        // Reset in INIT with cnt=17.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("r1_waddr", {27'd0, waddr}, 32'(k));
        end
        rst_in = 1'b1;
        tick();
        chk("r2_we", {31'd0, we}, 32'd0);
        chk("r2_init_done", {31'd0, init_done}, 32'd0);
        chk("r2_waddr", {27'd0, waddr}, 32'd0);
        $display("reset@cnt17: we=%0b init_done=%0b", we, init_done);
        rst_in = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick();
            chk("r2_seq_we", {31'd0, we}, 32'd1);
            chk("r2_seq_waddr", {27'd0, waddr}, 32'(k));
            chk("r2_seq_done", {31'd0, init_done}, (k == 31) ? 32'd1 : 32'd0);
        end
        $display("reinit: final waddr=%0d init_done=%0b", waddr, init_done);

        // Reset in RUN while requester 1 is valid.
        set_req(1, 5'd12, 32'h1234);
        req_valid = 3'b010;
        rst_in = 1'b1;
        #1;
        chk("r3_ready_rst", {29'd0, req_ready}, 32'd0);
        tick();
        chk("r3_we", {31'd0, we}, 32'd0);
        chk("r3_init_done", {31'd0, init_done}, 32'd0);
        rst_in = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            #1;
            chk("r3_ready_init", {29'd0, req_ready}, 32'd0);
            @(posedge clk_in);
            #1;
            chk("r3_seq_waddr", {27'd0, waddr}, 32'(k));
        end
        chk("r3_ready_run", {29'd0, req_ready}, 32'b010);
        tick();
        req_valid = 3'b000;
        chk("r3_w_we", {31'd0, we}, 32'd1);
        chk("r3_w_addr", {27'd0, waddr}, 32'd12);
        chk("r3_w_data", wdata, 32'h1234);
        $display("reset@run: write addr=%0d data=%h", waddr, wdata);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32 x 32-bit integer register file. It shares the register file's single write port (we/waddr/wdata) between several writeback sources, such as the ALU, load unit and CSR unit, using round-robin arbitration with a valid/ready handshake. After every reset it first runs a clear sequence that writes zero to x1..x31. It sits between the execute/memory writeback sources and the register file, and drives the register file's write port directly.

## Interface
Parameters:
- NREQ, default 3: number of writeback requesters (2..8).
- INIT_ZERO, default 1: 1 runs the x1..x31 clear sequence after reset; 0 skips it.

Ports:
- clk_in  in  1  core clock; all state changes on posedge.
- rst_in  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  5*NREQ  destination register of requester i, in bits [5i+4:5i].
- req_data  in  32*NREQ  write data of requester i, in bits [32i+31:32i].
- req_ready  out  NREQ  grant to requester i; combinational.
- we  out  1  register file write enable; registered.
- waddr  out  5  register file write address; registered.
- wdata  out  32  register file write data; registered.
- init_done  out  1  clear sequence finished and arbitration active; registered.

## Operation
- States:
  - INIT: active only when INIT_ZERO=1. Counter cnt runs 1..31. Each cycle loads {we=1, waddr=cnt, wdata=0} and increments cnt. At the edge that loads cnt=31, the state moves to RUN and init_done is set to 1.
  - RUN: normal arbitration. RUN is left only by reset.
- Reset entry: rst_in sampled high puts the block in INIT (or RUN if INIT_ZERO=0), with cnt=1 and rr_ptr=NREQ-1.
- Round-robin grant in RUN:
  - The grant goes to the first i with req_valid[i]=1, scanning upward from rr_ptr+1 modulo NREQ.
  - req_ready[grant]=1; all other req_ready bits are 0.
  - At most one req_ready bit is high in any cycle.
  - req_ready is 0 everywhere while in INIT or while rst_in=1.
- Transfer: occurs when req_valid[i] and req_ready[i] are both high. On that edge:
  - the output registers load {we=1, waddr=req_addr[i], wdata=req_data[i]};
  - rr_ptr is set to i.
- Writes to x0: a transfer with req_addr[i]=0 completes the handshake and updates rr_ptr, but loads we=0. The write is dropped, and no write to x0 is ever issued.
- No transfer in a RUN cycle: we loads 0. waddr and wdata hold their previous values.
- Requester rules:
  - A requester must hold its valid, addr and data stable until it sees ready.
  - Valid may deassert before a grant; a request withdrawn this way is simply not written.
- One write per cycle. Any number of requesters may be valid at once; NREQ simultaneous requests are all served within NREQ cycles.

## Timing
- Reset values, present in the cycle after any edge with rst_in=1:
  - we=0, waddr=0, wdata=0, init_done=0 (init_done=1 if INIT_ZERO=0).
  - req_ready=0 while rst_in=1.
- Clear sequence (INIT_ZERO=1):
  - The edges E1..E31 following reset release present waddr=1..31 in turn.
  - init_done=1 from E31 onward, so RUN begins after 31 cycles.
  - A request can be granted in the cycle presenting waddr=31; its write appears at E32.
- INIT_ZERO=0: RUN begins in the first cycle with rst_in low.
- Writeback latency:
  - A handshake at edge N presents we/waddr/wdata during cycle N..N+1.
  - The register file captures the write at the negedge within that cycle.
  - A read of the same register in the following cycle returns the new value.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- Reset mid-operation:
  - Sampling rst_in high in any state aborts the clear sequence or the pending arbitration.
  - Outputs return to their reset values, and the clear sequence restarts from cnt=1.
  - A request in flight at that point is not written; the requester re-presents it.

## Test plan
- Reset release, INIT_ZERO=1, all requesters valid:
  - required: we=1 for 31 consecutive cycles with waddr=1..31 and wdata=0;
  - req_ready=0 throughout, until the cycle presenting waddr=31;
  - init_done=1 from that cycle onward.
- NREQ=3, all three valid with addr 5/6/7 and data 0xA/0xB/0xC, held valid until granted, after init:
  - required: grants in order 0, 1, 2 on consecutive cycles;
  - the following cycles show waddr 5/6/7 with wdata 0xA/0xB/0xC, we=1 each.
- Requesters 0 and 2 both valid continuously, with requester 0 granted last:
  - required: grants alternate 2, 0, 2, 0;
  - requester 1 is never granted.
- Single request with addr=0, data=0xDEADBEEF:
  - required: req_ready=1 for one cycle;
  - we stays 0 in the following cycle.
- rst_in asserted for one cycle while in INIT with cnt=17:
  - required: we=0 and init_done=0 in the following cycle;
  - the sequence then restarts at waddr=1 and completes all 31 writes.
- Same assertion while in RUN with requester 1 valid:
  - required: req_ready=0 in the reset cycle and no write issued;
  - the grant to requester 1 occurs only after the new clear sequence ends.
